sipo_framed: RTL and testbench

SIPO_FRAMED -- requirements
Module: sipo_framed

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_framed.sv | 103 ++++++++++
 tb/tb_sipo_framed.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserialiser family: FSM state encoding,
// default word length and the reset-state selection helper.
package sipo_pkg;

    localparam int SIPO_WIDTH = 8;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    // Framed variants wait for a sync; free-running ones shift from reset release.
    function automatic sipo_state_t reset_state(input bit sync_req);
        return sync_req ? HUNT : SHIFT;
    endfunction

endpackage

// File: rtl/sipo_framed.sv
// Framed serial-in/parallel-out deserialiser with a one-deep output register,
// ready/valid hand-off and a sticky overrun flag for words lost to backpressure.
module sipo_framed
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int SYNC_REQ  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       serial_in,
    input  logic                       in_valid,
    input  logic                       sync,
    input  logic                       out_ready,
    input  logic                       clr_ovr,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam sipo_state_t       RST_STATE = reset_state(SYNC_REQ != 0);

    sipo_state_t       state, state_nxt;
    logic [WIDTH-1:0]  shreg, shreg_nxt;
    logic [WIDTH-1:0]  shift_base, shifted;
    logic [WIDTH-1:0]  data_nxt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic              out_valid_nxt, overrun_nxt;
    logic              accept, restart, word_done, load, drop;

    // A qualified sync always starts a fresh word, whether hunting or mid-word.
    assign restart   = in_valid && sync;
    assign accept    = in_valid && ((state == SHIFT) || sync);
    assign word_done = in_valid && !sync && (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign load      = word_done && (!out_valid || out_ready);
    assign drop      = word_done && !load;

    assign shift_base = restart ? '0 : shreg;

    // Bit order is fixed at elaboration: only the wiring of the shift differs.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shifted = {shift_base[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign shifted = {serial_in, shift_base[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        data_nxt      = data_out;

        if (accept) begin
            state_nxt = SHIFT;
            shreg_nxt = shifted;
            if (restart) begin
                bit_cnt_nxt = CNT_W'(1);
            end else if (word_done) begin
                bit_cnt_nxt = '0;
            end else begin
                bit_cnt_nxt = bit_cnt + 1'b1;
            end
        end

        if (load) begin
            data_nxt = shifted;
        end

        // A fresh load keeps out_valid high even while the old word is consumed.
        out_valid_nxt = load || (out_valid && !out_ready);
        // A drop on the same edge as clr_ovr must leave the flag set.
        overrun_nxt   = drop || (overrun && !clr_ovr);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            shreg     <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            data_out  <= data_nxt;
            out_valid <= out_valid_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_sipo_framed.sv
// Directed bench for sipo_framed: a vector table for the basic framed word,
// then hand-written sequences for hunt, backpressure, resync and reset.
module tb_sipo_framed;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       sync = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovr = 1'b0;

    logic [7:0] data_msb, data_lsb, data_ns;
    logic       valid_msb, valid_lsb, valid_ns;
    logic       ovr_msb, ovr_lsb, ovr_ns;
    logic [2:0] cnt_msb, cnt_lsb, cnt_ns;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sipo_framed #(.WIDTH(8), .MSB_FIRST(1), .SYNC_REQ(1)) dut_msb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .sync(sync), .out_ready(out_ready), .clr_ovr(clr_ovr),
        .data_out(data_msb), .out_valid(valid_msb), .overrun(ovr_msb), .bit_cnt(cnt_msb)
    );

    sipo_framed #(.WIDTH(8), .MSB_FIRST(0), .SYNC_REQ(1)) dut_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .sync(sync), .out_ready(out_ready), .clr_ovr(clr_ovr),
        .data_out(data_lsb), .out_valid(valid_lsb), .overrun(ovr_lsb), .bit_cnt(cnt_lsb)
    );

    sipo_framed #(.WIDTH(8), .MSB_FIRST(1), .SYNC_REQ(0)) dut_ns (
        .clk(clk), .rst(rst), .serial_in(serial_in), .in_valid(in_valid),
        .sync(sync), .out_ready(out_ready), .clr_ovr(clr_ovr),
        .data_out(data_ns), .out_valid(valid_ns), .overrun(ovr_ns), .bit_cnt(cnt_ns)
    );

    typedef struct {
        logic       s_in, vld, syn, rdy, clr;
        logic [7:0] e_data, e_lsb;
        logic       e_valid, e_ovr;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic y, input logic r, input logic c);
        serial_in = s; in_valid = v; sync = y; out_ready = r; clr_ovr = c;
        tick();
    endtask

    task automatic send_word(input logic [7:0] w, input logic sync_first,
                             input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++)
            drive(w[7-i], 1'b1, (i == 0) && sync_first, (i == 7) && rdy_last, (i == 7) && clr_last);
    endtask

    task automatic do_reset();
        serial_in = 1'b0; in_valid = 1'b0; sync = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int words;

        // Bits 1,0,1,1,0,0,1,0 framed by sync on the first bit: B2 MSB-first, 4D LSB-first.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd2};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd3};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd4};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd5};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd6};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd7};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b1, 1'b0, 3'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0, 1'b0, 3'd0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b0, 3'd0};

        do_reset();
        check("rst_data", data_msb, 8'h00);
        check("rst_valid", valid_msb, 1'b0);
        check("rst_ovr", ovr_msb, 1'b0);
        check("rst_cnt", cnt_msb, 3'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].s_in, vecs[i].vld, vecs[i].syn, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d_data", i), data_msb, vecs[i].e_data);
            check($sformatf("vec%0d_lsb", i), data_lsb, vecs[i].e_lsb);
            check($sformatf("vec%0d_valid", i), valid_msb, vecs[i].e_valid);
            check($sformatf("vec%0d_ovr", i), ovr_msb, vecs[i].e_ovr);
            check($sformatf("vec%0d_cnt", i), cnt_msb, vecs[i].e_cnt);
        end

        // Hunt: five unframed bits are ignored, then a framed A5 gives exactly one word.
        do_reset();
        words = 0;
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("hunt_cnt%0d", i), cnt_msb, 3'd0);
            words += int'(valid_msb);
        end
        check("nosync_cnt", cnt_ns, 3'd5);
        for (int i = 0; i < 8; i++) begin
            drive(8'hA5 >> (7 - i), 1'b1, i == 0, 1'b0, 1'b0);
            words += int'(valid_msb);
        end
        check("hunt_words", words, 1);
        check("hunt_data", data_msb, 8'hA5);
        check("hunt_ns_data", data_ns, 8'hA5);

        // Backpressure: second and third words are dropped, overrun is sticky.
        do_reset();
        send_word(8'h11, 1'b1, 1'b0, 1'b0);
        check("bp_w1_data", data_msb, 8'h11);
        check("bp_w1_valid", valid_msb, 1'b1);
        check("bp_w1_ovr", ovr_msb, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        check("bp_w2_data", data_msb, 8'h11);
        check("bp_w2_ovr", ovr_msb, 1'b1);
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        check("bp_w3_data", data_msb, 8'h11);
        check("bp_w3_ovr", ovr_msb, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_clr_ovr", ovr_msb, 1'b0);
        check("bp_clr_valid", valid_msb, 1'b1);
        send_word(8'h44, 1'b0, 1'b0, 1'b1);
        check("bp_drop_wins", ovr_msb, 1'b1);
        check("bp_drop_data", data_msb, 8'h11);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bp_clr2_ovr", ovr_msb, 1'b0);
        send_word(8'h5A, 1'b0, 1'b1, 1'b0);
        check("bp_swap_valid", valid_msb, 1'b1);
        check("bp_swap_data", data_msb, 8'h5A);
        check("bp_swap_ovr", ovr_msb, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("bp_consume_valid", valid_msb, 1'b0);
        check("bp_consume_data", data_msb, 8'h5A);

        // Resync: sync after three bits discards them.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("resync_cnt3", cnt_msb, 3'd3);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("resync_cnt1", cnt_msb, 3'd1);
        for (int i = 1; i < 8; i++)
            drive(8'h3C >> (7 - i), 1'b1, 1'b0, 1'b0, 1'b0);
        check("resync_data", data_msb, 8'h3C);
        check("resync_valid", valid_msb, 1'b1);
        check("resync_cnt0", cnt_msb, 3'd0);
        check("resync_ns_data", data_ns, 8'h3C);

        // Asynchronous reset mid-word with a pending word.
        do_reset();
        send_word(8'h81, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("arst_pre_cnt", cnt_msb, 3'd4);
        check("arst_pre_valid", valid_msb, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_data", data_msb, 8'h00);
        check("arst_valid", valid_msb, 1'b0);
        check("arst_ovr", ovr_msb, 1'b0);
        check("arst_cnt", cnt_msb, 3'd0);
        check("arst_ns_cnt", cnt_ns, 3'd0);
        #1 rst = 1'b0;
        send_word(8'hFF, 1'b1, 1'b0, 1'b0);
        check("arst_ff_data", data_msb, 8'hFF);
        check("arst_ff_lsb", data_lsb, 8'hFF);
        check("arst_ff_valid", valid_msb, 1'b1);
        check("arst_ff_ovr", ovr_msb, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
